// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
// Bundles the upstream result/handshake signals and the downstream
// result/flags/handshake signals of alu_result_stage.
//   master : the environment side (drives unit results, InValid, OutReady)
//   slave  : the stage itself (drives InReady, Result, Flags, OutValid,
//            OpError, OpCount)
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
);
    logic [1:0]         Op;
    logic [WIDTH-1:0]   AndResult;
    logic [WIDTH-1:0]   OrResult;
    logic [WIDTH-1:0]   SumResult;
    logic               CarryOut;
    logic               InValid;
    logic               InReady;
    logic [WIDTH-1:0]   Result;
    logic [2:0]         Flags;
    logic               OutValid;
    logic               OutReady;
    logic               OpError;
    logic [COUNT_W-1:0] OpCount;

    modport master (
        output Op, AndResult, OrResult, SumResult, CarryOut, InValid, OutReady,
        input  InReady, Result, Flags, OutValid, OpError, OpCount
    );

    modport slave (
        input  Op, AndResult, OrResult, SumResult, CarryOut, InValid, OutReady,
        output InReady, Result, Flags, OutValid, OpError, OpCount
    );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Output stage behind the AND / OR / adder units. Picks one unit result by
// Op, derives {Z, N, C} flags and buffers result+flags in a 2-entry FIFO
// with valid/ready handshakes on both sides.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears FIFO, OpError, OpCount)
//   bus  : alu_result_stage_if.slave
//          in : Op, AndResult, OrResult, SumResult, CarryOut, InValid, OutReady
//          out: InReady, Result, Flags, OutValid, OpError, OpCount
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_stage_if.slave  bus
);

    // Flags for a selected value: Z on zero, N from the MSB, C only for ADD.
    function automatic logic [2:0] calc_flags(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] value,
        input logic             carry
    );
        logic z;
        logic n;
        logic c;
        z = (value == '0);
        n = value[WIDTH-1];
        c = (op == 2'b10) ? carry : 1'b0;
        return {z, n, c};
    endfunction

    // FIFO storage and control state
    logic [WIDTH-1:0]   res_mem_q [2];
    logic [2:0]         flg_mem_q [2];
    logic [1:0]         count_q,    count_d;
    logic               wr_ptr_q,   wr_ptr_d;
    logic               rd_ptr_q,   rd_ptr_d;
    logic               op_error_q, op_error_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;

    logic [WIDTH-1:0]   sel_s;
    logic [2:0]         flags_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;

    // Result selection; the reserved opcode yields an all-zero value
    always_comb begin
        sel_s = '0;
        case (bus.Op)
            2'b00:   sel_s = bus.AndResult;
            2'b01:   sel_s = bus.OrResult;
            2'b10:   sel_s = bus.SumResult;
            default: sel_s = '0;
        endcase
    end

    assign flags_s = calc_flags(bus.Op, sel_s, bus.CarryOut);

    // Ready/valid are pure functions of the stored occupancy, so a full
    // FIFO refuses a push even when the consumer pops in the same cycle.
    assign in_ready_s  = (count_q < 2'd2);
    assign out_valid_s = (count_q != 2'd0);
    assign push_s      = bus.InValid && in_ready_s;
    assign pop_s       = out_valid_s && bus.OutReady;

    // Next-state logic for occupancy, pointers and status counters
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        op_error_d = op_error_q;
        op_count_d = op_count_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (push_s) begin
            wr_ptr_d   = ~wr_ptr_q;
            op_count_d = op_count_q + COUNT_W'(1);
            op_error_d = op_error_q | (bus.Op == 2'b11);
        end else begin
            wr_ptr_d   = wr_ptr_q;
            op_count_d = op_count_q;
            op_error_d = op_error_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers; reset drops every buffered entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            op_error_q   <= 1'b0;
            op_count_q   <= '0;
            res_mem_q[0] <= '0;
            res_mem_q[1] <= '0;
            flg_mem_q[0] <= 3'b000;
            flg_mem_q[1] <= 3'b000;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            op_error_q <= op_error_d;
            op_count_q <= op_count_d;
            if (push_s) begin
                res_mem_q[wr_ptr_q] <= sel_s;
                flg_mem_q[wr_ptr_q] <= flags_s;
            end
        end
    end

    // Head entry straight from storage; forced to zero while empty
    assign bus.Result   = out_valid_s ? res_mem_q[rd_ptr_q] : '0;
    assign bus.Flags    = out_valid_s ? flg_mem_q[rd_ptr_q] : 3'b000;
    assign bus.OutValid = out_valid_s;
    assign bus.InReady  = in_ready_s;
    assign bus.OpError  = op_error_q;
    assign bus.OpCount  = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Directed scenarios plus randomized traffic against a queue-based model of
// the stage. Inputs change on the falling edge; outputs are compared on the
// falling edge as well.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

    localparam int WIDTH   = 4;
    localparam int COUNT_W = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [2:0]       flg;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_result_stage_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t             mdl_q[$];
    logic             mdl_err;
    int unsigned      mdl_cnt;

    function automatic ent_t expected_entry(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] o, input logic [WIDTH-1:0] s,
                                            input logic c);
        ent_t e;
        int unsigned v;
        if (op == 2'd0)      v = a;
        else if (op == 2'd1) v = o;
        else if (op == 2'd2) v = s;
        else                 v = 0;
        e.res = v[WIDTH-1:0];
        e.flg = {(v == 0), (v >= (1 << (WIDTH - 1))), (op == 2'd2) && c};
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_q.delete();
            mdl_err <= 1'b0;
            mdl_cnt <= 0;
        end else begin
            if (bus.InValid && mdl_q.size() < 2) begin
                if (mdl_q.size() > 0 && bus.OutReady) void'(mdl_q.pop_front());
                mdl_q.push_back(expected_entry(bus.Op, bus.AndResult, bus.OrResult,
                                               bus.SumResult, bus.CarryOut));
                mdl_cnt <= (mdl_cnt + 1) % (1 << COUNT_W);
                if (bus.Op == 2'd3) mdl_err <= 1'b1;
            end else if (mdl_q.size() > 0 && bus.OutReady) begin
                void'(mdl_q.pop_front());
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [WIDTH-1:0] e_res;
        logic [2:0]       e_flg;
        e_res = '0;
        e_flg = 3'b000;
        if (mdl_q.size() > 0) begin
            e_res = mdl_q[0].res;
            e_flg = mdl_q[0].flg;
        end
        chk("InReady",  32'(bus.InReady),  32'(mdl_q.size() < 2));
        chk("OutValid", 32'(bus.OutValid), 32'(mdl_q.size() > 0));
        chk("Result",   32'(bus.Result),   32'(e_res));
        chk("Flags",    32'(bus.Flags),    32'(e_flg));
        chk("OpError",  32'(bus.OpError),  32'(mdl_err));
        chk("OpCount",  32'(bus.OpCount),  32'(mdl_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] val, input logic c,
                         input logic v, input logic r);
        bus.Op        = op;
        bus.AndResult = 4'($urandom);
        bus.OrResult  = 4'($urandom);
        bus.SumResult = 4'($urandom);
        bus.CarryOut  = c;
        if (op == 2'd0)      bus.AndResult = val;
        else if (op == 2'd1) bus.OrResult  = val;
        else if (op == 2'd2) bus.SumResult = val;
        bus.InValid  = v;
        bus.OutReady = r;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset then idle
        cycles(2);
        chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
        chk("rst_inready",  32'(bus.InReady),  32'd1);
        chk("rst_result",   32'(bus.Result),   32'd0);
        chk("rst_flags",    32'(bus.Flags),    32'd0);
        chk("rst_opcount",  32'(bus.OpCount),  32'd0);
        rst = 1'b0;
        cycles(1);

        // Single OR
        drive(2'd1, 4'b1010, 1'b0, 1'b1, 1'b1);
        cycles(1);
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("or_result",   32'(bus.Result),   32'hA);
        chk("or_flags",    32'(bus.Flags),    32'b010);
        chk("or_outvalid", 32'(bus.OutValid), 32'd1);
        chk("or_opcount",  32'(bus.OpCount),  32'd1);
        cycles(1);
        chk("or_drained",  32'(bus.OutValid), 32'd0);

        // ADD with carry producing zero
        drive(2'd2, 4'b0000, 1'b1, 1'b1, 1'b1);
        cycles(1);
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("add_flags",  32'(bus.Flags),  32'b101);
        chk("add_result", 32'(bus.Result), 32'd0);
        cycles(1);

        // Backpressure: fill, refuse third push, drain in order
        drive(2'd0, 4'b0011, 1'b0, 1'b1, 1'b0);
        cycles(1);
        drive(2'd1, 4'b0100, 1'b0, 1'b1, 1'b0);
        cycles(1);
        chk("bp_full_inready", 32'(bus.InReady), 32'd0);
        drive(2'd2, 4'b1111, 1'b1, 1'b1, 1'b0);
        cycles(1);
        chk("bp_refused_count", 32'(bus.OpCount), 32'd4);
        chk("bp_head_stable",   32'(bus.Result),  32'h3);
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cycles(1);
        chk("bp_second",  32'(bus.Result),  32'h4);
        chk("bp_ready",   32'(bus.InReady), 32'd1);
        cycles(1);
        chk("bp_empty",   32'(bus.OutValid), 32'd0);

        // Streaming with no bubbles
        for (int i = 0; i < 10; i++) begin
            drive(2'd1, 4'(i + 1), 1'b0, 1'b1, 1'b1);
            cycles(1);
            chk("stream_valid",  32'(bus.OutValid), 32'd1);
            chk("stream_result", 32'(bus.Result),   32'(i + 1));
        end
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cycles(1);
        chk("stream_count", 32'(bus.OpCount), 32'd14);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
            cycles(1);
        end
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cycles(3);

        // Reserved op, then asynchronous reset with two entries buffered
        drive(2'd3, 4'b0110, 1'b1, 1'b1, 1'b0);
        cycles(1);
        chk("rsv_result", 32'(bus.Result),  32'd0);
        chk("rsv_flags",  32'(bus.Flags),   32'b100);
        chk("rsv_error",  32'(bus.OpError), 32'd1);
        drive(2'd1, 4'b0101, 1'b0, 1'b1, 1'b0);
        cycles(1);
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rsv_full", 32'(bus.InReady), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_outvalid", 32'(bus.OutValid), 32'd0);
        chk("async_operror",  32'(bus.OpError),  32'd0);
        chk("async_inready",  32'(bus.InReady),  32'd1);
        chk("async_result",   32'(bus.Result),   32'd0);
        cycles(1);
        rst = 1'b0;
        cycles(1);

        // Counter wrap: 260 pushes on an 8-bit counter
        for (int i = 0; i < 260; i++) begin
            drive(2'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1);
            cycles(1);
        end
        drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cycles(2);
        chk("wrap_count", 32'(bus.OpCount), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
